// File: rtl/ppsiii_nco_bank.sv
// -----------------------------------------------------------------------------
// ppsiii_nco_bank
//
// Bank of NCH independent phase accumulators, each acting as a run-time
// programmable fractional-divide pulse generator. Every channel adds its STEP
// to an AW-bit accumulator each clock; the carry out of that addition is the
// wrap event. A per-channel mode selects what drives o_out: square wave, wrap
// tick, PWM against DUTY, or inverted square wave. Out of reset every channel
// is an enabled square wave running at roughly 1 Hz.
//
// Ports
//   i_clk    : system clock
//   i_reset  : synchronous active-high reset; beats i_sync and i_wr
//   i_wr     : single-cycle register write strobe
//   i_addr   : {channel[CW-1:0], reg[1:0]}; reg 0=STEP, 1=DUTY, 2=CTRL, 3=unused
//   i_data   : write data (CTRL: bit0 enable, bits[2:1] mode)
//   i_sync   : clears every accumulator, phase-aligning all channels
//   o_out    : per-channel registered mode output
//   o_tick   : per-channel registered one-cycle wrap pulse
// -----------------------------------------------------------------------------
module ppsiii_nco_bank #(
   parameter int              NCH           = 4,
   parameter int              AW            = 32,
   parameter longint unsigned CLOCK_RATE_HZ = 64'd100_000_000,
   parameter longint unsigned DEFAULT_STEP  =
      (((64'd1 << AW) / CLOCK_RATE_HZ) == 64'd0) ? 64'd1
                                                 : ((64'd1 << AW) / CLOCK_RATE_HZ),
   localparam int             CW            = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic            i_clk,
   input  logic            i_reset,
   input  logic            i_wr,
   input  logic [CW+1:0]   i_addr,
   input  logic [AW-1:0]   i_data,
   input  logic            i_sync,
   output logic [NCH-1:0]  o_out,
   output logic [NCH-1:0]  o_tick
);

   localparam logic [AW-1:0] STEP_RST = AW'(DEFAULT_STEP);
   localparam logic [AW-1:0] DUTY_RST = {1'b1, {(AW-1){1'b0}}};
   localparam logic [AW-1:0] ACC_ZERO = {AW{1'b0}};
   localparam logic [CW:0]   NCH_V    = (CW+1)'(NCH);

   localparam logic [1:0] REG_STEP = 2'd0;
   localparam logic [1:0] REG_DUTY = 2'd1;
   localparam logic [1:0] REG_CTRL = 2'd2;

   // Output selection for one channel given the freshly computed sum.
   function automatic logic mode_f(input logic [1:0]    mode,
                                   input logic [AW-1:0] sum,
                                   input logic          carry,
                                   input logic [AW-1:0] duty);
      logic r;
      case (mode)
         2'd0:    r = sum[AW-1];
         2'd1:    r = carry;
         2'd2:    r = (sum < duty);
         2'd3:    r = ~sum[AW-1];
         default: r = 1'b0;
      endcase
      return r;
   endfunction

   logic [AW-1:0]  acc_q  [NCH];
   logic [AW-1:0]  acc_d  [NCH];
   logic [AW-1:0]  step_q [NCH];
   logic [AW-1:0]  step_d [NCH];
   logic [AW-1:0]  duty_q [NCH];
   logic [AW-1:0]  duty_d [NCH];
   logic [1:0]     mode_q [NCH];
   logic [1:0]     mode_d [NCH];
   logic [NCH-1:0] en_q, en_d;
   logic [NCH-1:0] out_q, out_d;
   logic [NCH-1:0] tick_q, tick_d;

   logic [CW-1:0]  wr_ch_s;
   logic [1:0]     wr_reg_s;
   logic           wr_hit_s;

   // Address decode: channel indices at or beyond NCH never hit.
   always_comb begin
      wr_ch_s  = i_addr[CW+1:2];
      wr_reg_s = i_addr[1:0];
      wr_hit_s = i_wr && ({1'b0, wr_ch_s} < NCH_V);
   end

   // Register-file next state: writes land on the edge where i_wr is high.
   always_comb begin
      for (int c = 0; c < NCH; c++) begin
         step_d[c] = step_q[c];
         duty_d[c] = duty_q[c];
         mode_d[c] = mode_q[c];
         en_d[c]   = en_q[c];
         if (wr_hit_s && (wr_ch_s == CW'(c))) begin
            case (wr_reg_s)
               REG_STEP: step_d[c] = i_data;
               REG_DUTY: duty_d[c] = i_data;
               REG_CTRL: begin
                  en_d[c]   = i_data[0];
                  mode_d[c] = i_data[2:1];
               end
               default: begin
                  step_d[c] = step_q[c];
               end
            endcase
         end else begin
            step_d[c] = step_q[c];
         end
      end
   end

   // Accumulator and output next state. The update always uses the settings
   // held before this edge, so a new STEP first acts on the following cycle.
   always_comb begin
      for (int c = 0; c < NCH; c++) begin
         logic [AW:0] sum_v;
         sum_v     = {1'b0, acc_q[c]} + {1'b0, step_q[c]};
         acc_d[c]  = acc_q[c];
         tick_d[c] = 1'b0;
         out_d[c]  = 1'b0;
         if (!en_q[c]) begin
            // Disabled channels are held at zero in every mode.
            acc_d[c]  = ACC_ZERO;
            tick_d[c] = 1'b0;
            out_d[c]  = 1'b0;
         end else if (i_sync) begin
            // Sync forces the phase to zero; the output reflects sum = 0.
            acc_d[c]  = ACC_ZERO;
            tick_d[c] = 1'b0;
            out_d[c]  = mode_f(mode_q[c], ACC_ZERO, 1'b0, duty_q[c]);
         end else begin
            acc_d[c]  = sum_v[AW-1:0];
            tick_d[c] = sum_v[AW];
            out_d[c]  = mode_f(mode_q[c], sum_v[AW-1:0], sum_v[AW], duty_q[c]);
         end
      end
   end

   // State registers with synchronous reset to the ~1 Hz square-wave defaults.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         for (int c = 0; c < NCH; c++) begin
            acc_q[c]  <= ACC_ZERO;
            step_q[c] <= STEP_RST;
            duty_q[c] <= DUTY_RST;
            mode_q[c] <= 2'd0;
         end
         en_q   <= {NCH{1'b1}};
         out_q  <= {NCH{1'b0}};
         tick_q <= {NCH{1'b0}};
      end else begin
         for (int c = 0; c < NCH; c++) begin
            acc_q[c]  <= acc_d[c];
            step_q[c] <= step_d[c];
            duty_q[c] <= duty_d[c];
            mode_q[c] <= mode_d[c];
         end
         en_q   <= en_d;
         out_q  <= out_d;
         tick_q <= tick_d;
      end
   end

   assign o_out  = out_q;
   assign o_tick = tick_q;

endmodule

// File: tb/tb_ppsiii_nco_bank.sv
// -----------------------------------------------------------------------------
// tb_ppsiii_nco_bank
//
// Directed bench for ppsiii_nco_bank built with AW=8, NCH=4, DEFAULT_STEP=1,
// plus a second NCH=3 instance for out-of-range channel writes. Stimulus pushes
// the expected outputs for the current cycle into a queue; a monitor on the
// falling edge pops and compares them.
// -----------------------------------------------------------------------------
module tb_ppsiii_nco_bank;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       wr = 1'b0;
   logic [3:0] addr = 4'd0;
   logic [7:0] data = 8'd0;
   logic       sync = 1'b0;
   logic [3:0] out, tick;

   logic       wr3 = 1'b0;
   logic [3:0] addr3 = 4'd0;
   logic [7:0] data3 = 8'd0;
   logic [2:0] out3, tick3;

   int cyc = 0;
   int checks = 0;
   int errors = 0;

   typedef struct {
      int         cyc;
      string      nm;
      logic [3:0] m;
      logic [3:0] eo;
      logic [3:0] et;
      logic [2:0] m3;
      logic [2:0] eo3;
      logic [2:0] et3;
   } exp_t;

   exp_t q[$];
   exp_t e;

   ppsiii_nco_bank #(.NCH(4), .AW(8), .DEFAULT_STEP(64'd1)) dut (
      .i_clk(clk), .i_reset(rst), .i_wr(wr), .i_addr(addr), .i_data(data),
      .i_sync(sync), .o_out(out), .o_tick(tick)
   );

   ppsiii_nco_bank #(.NCH(3), .AW(8), .DEFAULT_STEP(64'd1)) dut3 (
      .i_clk(clk), .i_reset(rst), .i_wr(wr3), .i_addr(addr3), .i_data(data3),
      .i_sync(sync), .o_out(out3), .o_tick(tick3)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: compare every expectation due at this cycle.
   always @(negedge clk) begin
      while (q.size() > 0 && q[0].cyc <= cyc) begin
         e = q.pop_front();
         checks++;
         if (e.cyc != cyc ||
             (out & e.m) !== (e.eo & e.m) || (tick & e.m) !== (e.et & e.m) ||
             (out3 & e.m3) !== (e.eo3 & e.m3) || (tick3 & e.m3) !== (e.et3 & e.m3)) begin
            errors++;
            $display("FAIL %s cyc=%0d/%0d got out=%b tick=%b out3=%b tick3=%b want out=%b tick=%b out3=%b tick3=%b mask=%b/%b",
                     e.nm, cyc, e.cyc, out & e.m, tick & e.m, out3 & e.m3, tick3 & e.m3,
                     e.eo & e.m, e.et & e.m, e.eo3 & e.m3, e.et3 & e.m3, e.m, e.m3);
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog cyc=%0d expected completion", cyc);
      $fatal(1, "watchdog");
   end

   task automatic step_clk();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input string nm, input logic [3:0] m, input logic [3:0] eo,
                       input logic [3:0] et, input logic [2:0] m3,
                       input logic [2:0] eo3, input logic [2:0] et3);
      exp_t x;
      x.cyc = cyc; x.nm = nm; x.m = m; x.eo = eo; x.et = et;
      x.m3 = m3; x.eo3 = eo3; x.et3 = et3;
      q.push_back(x);
   endtask

   task automatic push4(input string nm, input logic [3:0] m,
                        input logic [3:0] eo, input logic [3:0] et);
      push(nm, m, eo, et, 3'b000, 3'b000, 3'b000);
   endtask

   task automatic wreg(input int ch, input int r, input logic [7:0] d);
      addr = 4'(ch * 4 + r);
      data = d;
      wr   = 1'b1;
      step_clk();
      wr   = 1'b0;
   endtask

   task automatic do_sync();
      sync = 1'b1;
      step_clk();
      sync = 1'b0;
   endtask

   initial begin
      logic b;
      logic t;
      int   a;

      // Reset state of both instances.
      step_clk();
      step_clk();
      push("reset", 4'b1111, 4'b0000, 4'b0000, 3'b111, 3'b000, 3'b000);
      rst = 1'b0;

      // 1: ch0 step 64 from a synced zero -> period 4 square and tick.
      wreg(0, 0, 8'd64);
      do_sync();
      push4("t1_sync", 4'b0001, 4'b0000, 4'b0000);
      for (int k = 1; k <= 8; k++) begin
         step_clk();
         b = ((64 * k) % 256) >= 128;
         t = (k % 4) == 0;
         push4("t1_ch0", 4'b0001, {3'b000, b}, {3'b000, t});
      end

      // 2: ch1 PWM, step 3, duty 64, over 256 cycles.
      wreg(1, 0, 8'd3);
      wreg(1, 1, 8'd64);
      wreg(1, 2, 8'd5);
      do_sync();
      push4("t2_sync", 4'b0010, 4'b0010, 4'b0000);
      for (int k = 1; k <= 256; k++) begin
         step_clk();
         a = (3 * k) % 256;
         b = a < 64;
         t = ((3 * k) / 256) != ((3 * (k - 1)) / 256);
         push4("t2_pwm", 4'b0010, {2'b00, b, 1'b0}, {2'b00, t, 1'b0});
      end

      // 3: ch2 step 100 then step 1 mid-stream; PWM duty 46 exposes acc.
      wreg(2, 1, 8'd46);
      wreg(2, 2, 8'd5);
      wreg(2, 0, 8'd100);
      do_sync();
      push4("t3_s0", 4'b0100, 4'b0100, 4'b0000);
      step_clk();
      push4("t3_s1", 4'b0100, 4'b0000, 4'b0000);
      step_clk();
      push4("t3_s2", 4'b0100, 4'b0000, 4'b0000);
      wreg(2, 0, 8'd1);
      push4("t3_wrap44", 4'b0100, 4'b0100, 4'b0100);
      step_clk();
      push4("t3_acc45", 4'b0100, 4'b0100, 4'b0000);
      step_clk();
      push4("t3_acc46", 4'b0100, 4'b0000, 4'b0000);

      // 4: all channels synced, then sync together with a STEP write.
      wreg(3, 0, 8'd5);
      do_sync();
      push4("t4_sync", 4'b1111, 4'b0110, 4'b0000);
      step_clk();
      push4("t4_s1", 4'b1111, 4'b0110, 4'b0000);
      step_clk();
      push4("t4_s2", 4'b1111, 4'b0111, 4'b0000);
      sync = 1'b1;
      wreg(3, 0, 8'd128);
      sync = 1'b0;
      push4("t4_syncwr", 4'b1111, 4'b0110, 4'b0000);
      step_clk();
      push4("t4_sw1", 4'b1111, 4'b1110, 4'b0000);
      step_clk();
      push4("t4_sw2", 4'b1111, 4'b0111, 4'b1000);

      // 5: ch3 disabled in mode 3, then re-enabled with step 16.
      wreg(3, 2, 8'd6);
      step_clk();
      push4("t5_dis", 4'b1000, 4'b0000, 4'b0000);
      wreg(3, 0, 8'd16);
      push4("t5_dis2", 4'b1000, 4'b0000, 4'b0000);
      wreg(3, 2, 8'd7);
      push4("t5_reen", 4'b1000, 4'b0000, 4'b0000);
      for (int k = 1; k <= 8; k++) begin
         step_clk();
         b = (16 * k) < 128;
         push4("t5_inv", 4'b1000, {b, 3'b000}, 4'b0000);
      end

      // 6: reset mid-operation beats a concurrent write and sync.
      rst  = 1'b1;
      sync = 1'b1;
      wreg(0, 2, 8'd0);
      rst  = 1'b0;
      sync = 1'b0;
      push("t6_reset", 4'b1111, 4'b0000, 4'b0000, 3'b111, 3'b000, 3'b000);
      for (int k = 1; k <= 256; k++) begin
         step_clk();
         b = (k % 256) >= 128;
         t = (k == 256);
         push("t6_default", 4'b1111, {4{b}}, {4{t}}, 3'b111, {3{b}}, {3{t}});
         if (k == 1) begin
            addr  = 4'd3;     // ch0, reg 3
            data  = 8'd0;
            wr    = 1'b1;
            addr3 = 4'hC;     // ch3 STEP on the 3-channel build
            data3 = 8'd0;
            wr3   = 1'b1;
         end else if (k == 2) begin
            wr    = 1'b0;
            addr3 = 4'hE;     // ch3 CTRL on the 3-channel build
         end else begin
            wr3   = 1'b0;
         end
      end
      wreg(1, 2, 8'd5);
      for (int j = 1; j <= 130; j++) begin
         step_clk();
         b = (1 + j) < 128;
         push4("t6_dutydef", 4'b0010, {2'b00, b, 1'b0}, 4'b0000);
      end

      repeat (3) step_clk();
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain pending=%0d want 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
